// File: rtl/cpu_fpu_addsub_issue_if.sv
// cpu_fpu_addsub_issue_if: dispatch-side and adder-side handshake bundle for the FADD.S/FSUB.S issue stage
interface cpu_fpu_addsub_issue_if;
  logic        i_request;
  logic        i_sub;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        o_ready;
  logic [31:0] o_result;
  logic [4:0]  o_fflags;
  logic        o_add_request;
  logic [31:0] o_add_op1;
  logic [31:0] o_add_op2;
  logic        i_add_ready;
  logic [31:0] i_add_result;
  modport slave (
    input  i_request, i_sub, i_op1, i_op2, i_add_ready, i_add_result,
    output o_ready, o_result, o_fflags, o_add_request, o_add_op1, o_add_op2
  );
  modport master (
    output i_request, i_sub, i_op1, i_op2, i_add_ready, i_add_result,
    input  o_ready, o_result, o_fflags, o_add_request, o_add_op1, o_add_op2
  );
endinterface

// File: rtl/cpu_fpu_addsub_issue.sv
// cpu_fpu_addsub_issue: FADD.S/FSUB.S issue stage feeding the FPU adder; define FPU_ADDSUB_ZERO_BYPASS_EN to resolve zero operands without the adder
module cpu_fpu_addsub_issue (
  input logic i_clock,
  input logic i_reset,
  cpu_fpu_addsub_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] op2_eff;
  logic [31:0] bypass_res;
  logic        bypass;
  logic        nv;
  logic        nv_q;
  logic        of;
  function automatic logic exp_max(input logic [30:0] x);
    return x[30:23] == 8'hff;
  endfunction
  function automatic logic is_nan(input logic [30:0] x);
    return exp_max(x) && x[22:0] != 23'd0;
  endfunction
  function automatic logic is_snan(input logic [30:0] x);
    return is_nan(x) && !x[22];
  endfunction
  function automatic logic is_inf(input logic [30:0] x);
    return exp_max(x) && x[22:0] == 23'd0;
  endfunction
  assign op2_eff = {bus.i_op2[31] ^ bus.i_sub, bus.i_op2[30:0]};
  assign nv = is_snan(bus.i_op1[30:0]) || is_snan(op2_eff[30:0]) ||
              (is_inf(bus.i_op1[30:0]) && is_inf(op2_eff[30:0]) && bus.i_op1[31] != op2_eff[31]);
  assign of = is_inf(bus.i_add_result[30:0]) && !exp_max(bus.o_add_op1[30:0]) && !exp_max(bus.o_add_op2[30:0]);
`ifdef FPU_ADDSUB_ZERO_BYPASS_EN
  logic z1, z2;
  assign z1 = bus.i_op1[30:0] == 31'd0;
  assign z2 = op2_eff[30:0] == 31'd0;
  assign bypass = (z1 || z2) && !is_nan(bus.i_op1[30:0]) && !is_nan(op2_eff[30:0]);
  assign bypass_res = (z1 && z2) ? {bus.i_op1[31] & op2_eff[31], 31'd0} : z1 ? op2_eff : bus.i_op1;
`else
  assign bypass = 1'b0;
  assign bypass_res = 32'd0;
`endif
  // next-state selection for the request/adder handshake
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.i_request ? (bypass ? DONE : ISSUE) : IDLE;
      ISSUE:   state_nx = bus.i_add_ready ? DRAIN : ISSUE;
      DRAIN:   state_nx = bus.i_add_ready ? DRAIN : DONE;
      default: state_nx = bus.i_request ? DONE : IDLE;
    endcase
  end
  // state register plus operand, result and flag latches
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state             <= IDLE;
      bus.o_ready       <= 1'b0;
      bus.o_add_request <= 1'b0;
      bus.o_result      <= 32'd0;
      bus.o_fflags      <= 5'd0;
      bus.o_add_op1     <= 32'd0;
      bus.o_add_op2     <= 32'd0;
      nv_q              <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.i_request) begin
          bus.o_add_op1 <= bus.i_op1;
          bus.o_add_op2 <= op2_eff;
          nv_q          <= nv;
          if (bypass) begin
            bus.o_result <= bypass_res;
            bus.o_fflags <= 5'd0;
            bus.o_ready  <= 1'b1;
          end else begin
            bus.o_add_request <= 1'b1;
          end
        end
        ISSUE: if (bus.i_add_ready) begin
          bus.o_result      <= bus.i_add_result;
          bus.o_fflags      <= {nv_q, 1'b0, of, 1'b0, of};
          bus.o_add_request <= 1'b0;
        end
        DRAIN: if (!bus.i_add_ready) bus.o_ready <= 1'b1;
        default: if (!bus.i_request) bus.o_ready <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_fpu_addsub_issue.sv
// tb_cpu_fpu_addsub_issue: directed vectors for the FADD.S/FSUB.S issue stage against a latency-programmable adder model
module tb_cpu_fpu_addsub_issue;
`ifdef FPU_ADDSUB_ZERO_BYPASS_EN
  localparam bit byp_en = 1'b1;
`else
  localparam bit byp_en = 1'b0;
`endif
  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic [31:0] add_res;
    logic [31:0] exp_op2;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
    int          lat;
    bit          byp;
  } vec_t;
  logic i_clock = 1'b0;
  logic i_reset = 1'b0;
  int total = 0;
  int bad = 0;
  int lat = 2;
  int acnt = 0;
  logic [31:0] add_res = 32'd0;
  vec_t vt[11];
  cpu_fpu_addsub_issue_if bus();
  cpu_fpu_addsub_issue dut (.i_clock(i_clock), .i_reset(i_reset), .bus(bus));
  always #5 i_clock = ~i_clock;
  // adder model: raises ready so the issue stage samples it L cycles after the request, drops it once the request goes away
  always_ff @(posedge i_clock) begin
    if (!i_reset || !bus.o_add_request) begin
      bus.i_add_ready <= 1'b0;
      acnt <= 0;
    end else if (!bus.i_add_ready) begin
      if (acnt == lat - 2) bus.i_add_ready <= 1'b1;
      else acnt <= acnt + 1;
    end
  end
  assign bus.i_add_result = bus.i_add_ready ? add_res : 32'hdeadbeef;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string tag);
    int cyc;
    bit seen;
    bit byp;
    int exp_cyc;
    logic [31:0] res_hold;
    byp = byp_en && v.byp;
    exp_cyc = byp ? 1 : v.lat + 3;
    lat = v.lat;
    add_res = v.add_res;
    bus.i_op1 = v.op1;
    bus.i_op2 = v.op2;
    bus.i_sub = v.sub;
    bus.i_request = 1'b1;
    @(posedge i_clock); #1;
    bus.i_op1 = ~v.op1;
    bus.i_op2 = ~v.op2;
    bus.i_sub = ~v.sub;
    cyc = 1;
    seen = bus.o_add_request;
    chk({tag, "_add_op1"}, bus.o_add_op1, v.op1);
    chk({tag, "_add_op2"}, bus.o_add_op2, v.exp_op2);
    chk({tag, "_add_req_c1"}, {31'd0, bus.o_add_request}, {31'd0, !byp});
    while (!bus.o_ready && cyc < 100) begin
      @(posedge i_clock); #1;
      cyc++;
      seen |= bus.o_add_request;
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_used_adder"}, {31'd0, seen}, {31'd0, !byp});
    chk({tag, "_result"}, bus.o_result, v.exp_res);
    chk({tag, "_fflags"}, {27'd0, bus.o_fflags}, {27'd0, v.exp_flags});
    res_hold = v.exp_res;
    repeat (2) @(posedge i_clock);
    #1;
    chk({tag, "_ready_held"}, {31'd0, bus.o_ready}, 32'd1);
    chk({tag, "_result_held"}, bus.o_result, res_hold);
    bus.i_request = 1'b0;
    @(posedge i_clock); #1;
    chk({tag, "_ready_drop"}, {31'd0, bus.o_ready}, 32'd0);
  endtask
  initial begin
    vt[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 32'h40000000, 32'h40400000, 5'b00000, 10, 1'b0};
    vt[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'hBF800000, 32'h40000000, 5'b00000, 3, 1'b0};
    vt[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2, 1'b0};
    vt[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 5'b00101, 4, 1'b0};
    vt[4]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 5'b00000, 3, 1'b1};
    vt[5]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'hFFC00000, 32'h3F800000, 32'hFFC00000, 5'b10000, 2, 1'b0};
    vt[6]  = '{32'hFF800000, 32'h7F800000, 1'b0, 32'hFFC00000, 32'h7F800000, 32'hFFC00000, 5'b10000, 5, 1'b0};
    vt[7]  = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 5'b00000, 2, 1'b0};
    vt[8]  = '{32'h7FC00000, 32'h00000000, 1'b0, 32'h7FC00000, 32'h00000000, 32'h7FC00000, 5'b00000, 2, 1'b0};
    vt[9]  = '{32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 6, 1'b1};
    vt[10] = '{32'h3F800000, 32'hC0000000, 1'b1, 32'h40400000, 32'h40000000, 32'h40400000, 5'b00000, 2, 1'b0};
    bus.i_request = 1'b0;
    bus.i_sub = 1'b0;
    bus.i_op1 = 32'd0;
    bus.i_op2 = 32'd0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_add_req", {31'd0, bus.o_add_request}, 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    chk("rst_fflags", {27'd0, bus.o_fflags}, 32'd0);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    for (int i = 0; i < 11; i++) run(vt[i], $sformatf("v%0d", i));
    lat = 10;
    add_res = 32'h12345678;
    bus.i_op1 = 32'h3F800000;
    bus.i_op2 = 32'h3F800000;
    bus.i_sub = 1'b0;
    bus.i_request = 1'b1;
    repeat (4) @(posedge i_clock);
    #1;
    chk("issue_add_req", {31'd0, bus.o_add_request}, 32'd1);
    bus.i_request = 1'b0;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    chk("rst_issue_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_issue_add_req", {31'd0, bus.o_add_request}, 32'd0);
    chk("rst_issue_add_op1", bus.o_add_op1, 32'd0);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    lat = 2;
    add_res = 32'h40000000;
    bus.i_request = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    chk("drain_add_req", {31'd0, bus.o_add_request}, 32'd0);
    chk("drain_result", bus.o_result, 32'h40000000);
    chk("drain_ready", {31'd0, bus.o_ready}, 32'd0);
    bus.i_request = 1'b0;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    chk("rst_drain_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_drain_add_req", {31'd0, bus.o_add_request}, 32'd0);
    chk("rst_drain_result", bus.o_result, 32'd0);
    chk("rst_drain_add_op2", bus.o_add_op2, 32'd0);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    run('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 32'h3F800000, 32'h40000000, 5'b00000, 4, 1'b0}, "post_rst");
    lat = 3;
    add_res = 32'h40400000;
    bus.i_op1 = 32'h3F800000;
    bus.i_op2 = 32'h40000000;
    bus.i_request = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    bus.i_request = 1'b0;
    repeat (10) @(posedge i_clock);
    #1;
    chk("abort_ready", {31'd0, bus.o_ready}, 32'd0);
    chk("abort_add_req", {31'd0, bus.o_add_request}, 32'd0);
    run(vt[1], "post_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
